// File: rtl/pipeline_pkg.sv
// Shared types and width defaults for the memory arbiter.
package pipeline_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_ME = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection between fetch (IF) and memory (ME) stages.
module arb_pick (
    input  logic if_req,
    input  logic me_req,
    input  logic last_grant,
    output logic grant_if,
    output logic grant_me
);

    // last_grant high means ME won most recently, so IF wins the next tie.
    always_comb begin
        grant_me = me_req && !(if_req && last_grant);
        grant_if = if_req && !grant_me;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (IF/ME) arbiter onto a single registered memory port.
// Define MEM_ARB_RR_EN for round-robin on ties; otherwise ME has fixed priority.
module mem_arbiter
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              me_req,
    input  logic              me_we,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [DATA_W-1:0] me_wdata,
    output logic [DATA_W-1:0] me_rdata,
    output logic              me_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_me
);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] me_rdata_q, me_rdata_d;
    logic              grant_if, grant_me;
    logic              last_grant;

`ifdef MEM_ARB_RR_EN
    logic              last_me_q, last_me_d;
    assign last_grant = last_me_q;
`else
    assign last_grant = 1'b0;
`endif

    arb_pick u_pick (
        .if_req     (if_req),
        .me_req     (me_req),
        .last_grant (last_grant),
        .grant_if   (grant_if),
        .grant_me   (grant_me)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        me_rdata_d  = me_rdata_q;
        if_ack      = 1'b0;
        me_ack      = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_me_d   = last_me_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_me) begin
                    state_d     = SERVE_ME;
                    mem_req_d   = 1'b1;
                    mem_we_d    = me_we;
                    mem_addr_d  = me_addr;
                    mem_wdata_d = me_wdata;
`ifdef MEM_ARB_RR_EN
                    last_me_d   = 1'b1;
`endif
                end else if (grant_if) begin
                    state_d     = SERVE_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
`ifdef MEM_ARB_RR_EN
                    last_me_d   = 1'b0;
`endif
                end
            end
            SERVE_IF: begin
                if (mem_ready) begin
                    if_ack     = 1'b1;
                    if_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            SERVE_ME: begin
                if (mem_ready) begin
                    me_ack     = 1'b1;
                    me_rdata_d = mem_rdata;
                    mem_req_d  = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            me_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            last_me_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            me_rdata_q  <= me_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_me_q   <= last_me_d;
`endif
        end
    end

    // Read data passes through in the ack cycle and is held afterwards.
    assign if_rdata  = if_rdata_d;
    assign me_rdata  = me_rdata_d;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign stall_if  = if_req && !if_ack;
    assign stall_me  = me_req && !me_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic vs a transaction model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_0;
    logic          if_req, me_req, me_we, mem_ready;
    logic [AW-1:0] if_addr, me_addr;
    logic [DW-1:0] me_wdata, mem_rdata;
    logic [DW-1:0] if_rdata, me_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_ack, me_ack, mem_req, mem_we, stall_if, stall_me;

    always #5 clock = ~clock;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset_0   (reset_0),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .me_req    (me_req),
        .me_we     (me_we),
        .me_addr   (me_addr),
        .me_wdata  (me_wdata),
        .me_rdata  (me_rdata),
        .me_ack    (me_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_me  (stall_me)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model: one outstanding access, owner, and captured request.
    bit            m_busy, m_is_me, m_we, m_last_me, m_me_ok;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_if_rd, m_me_rd;

    // Snapshot of DUT outputs from the most recent step.
    logic          s_if_ack, s_me_ack, s_mem_req, s_mem_we, s_stall_if;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_if_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_is_me = 0; m_we = 0; m_last_me = 0; m_me_ok = 1;
        m_addr = '0; m_wdata = '0; m_if_rd = '0; m_me_rd = '0;
    endtask

    // Called at posedge+1 with this cycle's inputs applied; returns at next posedge+1.
    task automatic step();
        bit e_if_ack, e_me_ack, pick_me;
        #3;
        e_if_ack = m_busy && !m_is_me && mem_ready;
        e_me_ack = m_busy && m_is_me && mem_ready;
        s_if_ack = if_ack; s_me_ack = me_ack; s_mem_req = mem_req; s_mem_we = mem_we;
        s_mem_addr = mem_addr; s_if_rdata = if_rdata; s_stall_if = stall_if;
        chk("mem_req", mem_req, m_busy);
        if (m_busy) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_ack", if_ack, e_if_ack);
        chk("me_ack", me_ack, e_me_ack);
        chk("ack_excl", if_ack && me_ack, 1'b0);
        chk("if_rdata", if_rdata, e_if_ack ? mem_rdata : m_if_rd);
        if (e_me_ack && !m_we) chk("me_rdata", me_rdata, mem_rdata);
        else if (!e_me_ack && m_me_ok) chk("me_rdata_hold", me_rdata, m_me_rd);
        chk("stall_if", stall_if, if_req && !e_if_ack);
        chk("stall_me", stall_me, me_req && !e_me_ack);
        if (!reset_0) model_reset();
        else if (m_busy) begin
            if (mem_ready) begin
                m_busy = 0;
                if (!m_is_me) m_if_rd = mem_rdata;
                else if (m_we) m_me_ok = 0;
                else begin m_me_rd = mem_rdata; m_me_ok = 1; end
            end
        end else if (me_req || if_req) begin
            pick_me = me_req && (!if_req || !RR || !m_last_me);
            m_busy = 1; m_is_me = pick_me; m_last_me = pick_me;
            if (pick_me) begin m_we = me_we; m_addr = me_addr; m_wdata = me_wdata; end
            else begin m_we = 0; m_addr = if_addr; end
        end
        @(posedge clock); #1;
    endtask

    task automatic apply_reset();
        reset_0 = 0; if_req = 0; me_req = 0; me_we = 0; mem_ready = 0;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_if_rdata", if_rdata, '0);
        chk("rst_me_rdata", me_rdata, '0);
        model_reset();
        step();
        reset_0 = 1;
    endtask

    initial begin
        logic order [4];
        int   n, acks;
        if_addr = '0; me_addr = '0; me_wdata = '0; mem_rdata = '0;
        apply_reset();

        // Ready strobe while idle with no requests is ignored.
        mem_ready = 1;
        for (int i = 0; i < 3; i++) begin mem_rdata = $urandom; step(); end
        chk("idle_ready_noack", s_if_ack || s_me_ack, 1'b0);
        mem_ready = 0;

        // Minimum-latency fetch read.
        if_req = 1; if_addr = 32'h40; step();
        mem_ready = 1; mem_rdata = 32'h2008_0001; step();
        chk("lat_mem_req", s_mem_req, 1'b1);
        chk("lat_if_ack", s_if_ack, 1'b1);
        chk("lat_if_rdata", s_if_rdata, 32'h2008_0001);
        if_req = 0; mem_ready = 0; step();
        chk("lat_stall_if", s_stall_if, 1'b0);

        // Simultaneous requests: ME write first with two wait cycles, then IF.
        if_req = 1; if_addr = 32'h80; me_req = 1; me_we = 1;
        me_addr = 32'h100; me_wdata = 32'hDEAD_BEEF; step();
        step();
        chk("wr_issued_we", s_mem_we, 1'b1);
        chk("wr_issued_addr", s_mem_addr, 32'h100);
        step();
        mem_ready = 1; mem_rdata = $urandom; step();
        chk("wr_me_ack", s_me_ack, 1'b1);
        me_req = 0; me_we = 0; mem_ready = 0; step();
        chk("gap_mem_req", s_mem_req, 1'b0);
        mem_ready = 1; mem_rdata = $urandom; step();
        chk("if_after_wr_addr", s_mem_addr, 32'h80);
        chk("if_after_wr_ack", s_if_ack, 1'b1);
        if_req = 0; mem_ready = 0; step();

        // ME drops its request mid-access: exactly one ack still arrives.
        me_req = 1; me_addr = 32'h300; step();
        me_req = 0; acks = 0;
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i >= 2); mem_rdata = $urandom; step();
            acks += int'(s_me_ack);
        end
        chk("drop_one_ack", acks, 1);
        mem_ready = 0;

        // Reset during an ME wait discards the access.
        me_req = 1; me_addr = 32'h200; step();
        step();
        reset_0 = 0; mem_ready = 1; me_req = 0;
        #1;
        chk("mid_rst_mem_req", mem_req, 1'b0);
        chk("mid_rst_me_ack", me_ack, 1'b0);
        model_reset();
        step();
        reset_0 = 1; mem_ready = 0; step();
        chk("post_rst_idle", s_mem_req, 1'b0);
        if_req = 1; if_addr = 32'h44; step();
        mem_ready = 1; mem_rdata = $urandom; step();
        chk("post_rst_if_ack", s_if_ack, 1'b1);
        if_req = 0; mem_ready = 0; step();

        // Both requests held across four accesses.
        apply_reset();
        for (int i = 0; i < 4; i++) order[i] = 1'bx;
        if_req = 1; me_req = 1; me_we = 0; mem_ready = 1; n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            mem_rdata = $urandom; step();
            if (s_me_ack) begin order[n] = 1'b1; n++; me_addr = $urandom; end
            if (s_if_ack && n < 4) begin order[n] = 1'b0; n++; if_addr = $urandom; end
        end
        chk("arb_grant_count", n, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("arb_order_%0d", i), order[i], RR ? (i % 2 == 0) : 1'b1);
        if_req = 0; me_req = 0; mem_ready = 0; step();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if (s_me_ack || !me_req) begin
                me_req = ($urandom_range(0, 2) != 0); me_we = $urandom_range(0, 1);
                me_addr = $urandom; me_wdata = $urandom;
            end
            if (s_if_ack || !if_req) begin
                if_req = ($urandom_range(0, 2) != 0); if_addr = $urandom;
            end
            mem_ready = $urandom_range(0, 1); mem_rdata = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
